// File: rtl/rf_2p_msk_bank.sv
// rf_2p_msk_bank: behavioural two-port register-file bank.
// SIZE parallel arrays of WORDWD x DWD sharing one read and one write address,
// with per-lane write mask, per-array write enable, registered read with valid,
// post-reset zero-fill sequencer and out-of-range address detection.
// Optional macro: RF_BYPASS_EN selects write-first behaviour for a same-cycle
// read and write to the same address (default is read-first).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | zero-fill in progress, one word per cycle, accesses ignored
// ST_IDLE | fill done, reads and writes accepted
module rf_2p_msk_bank #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int LANEWD = 4,
    parameter int SIZE   = 1,
    parameter int AWD    = $clog2(WORDWD)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic                      o_ready,
    input  logic                      i_read,
    input  logic [AWD-1:0]            i_raddr,
    output logic                      o_rvalid,
    output logic [SIZE-1:0][DWD-1:0]  o_rdata,
    input  logic                      i_write,
    input  logic [AWD-1:0]            i_waddr,
    input  logic [SIZE-1:0]           i_wen,
    input  logic [DWD/LANEWD-1:0]     i_wmsk,
    input  logic [SIZE-1:0][DWD-1:0]  i_wdata,
    output logic                      o_err
);

    localparam int NLANE = DWD / LANEWD;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t                     state_q;
    logic [AWD-1:0]             fill_q;
    logic                       ready_q;
    logic                       rvalid_q;
    logic [SIZE-1:0][DWD-1:0]   rdata_q;
    logic                       err_q;
    logic [DWD-1:0]             mem_q [SIZE][WORDWD];

    logic                       acc_ok;
    logic                       rd_in, rd_oor, wr_in, wr_oor;
    logic                       fill_we;
    logic [DWD-1:0]             lane_bits;
    logic [SIZE-1:0][DWD-1:0]   rd_word_d;

    // Access qualification; a reset cycle never touches storage.
    always_comb begin
        acc_ok  = (state_q == ST_IDLE) && !i_rst;
        rd_in   = acc_ok && i_read  && (32'(i_raddr) <  WORDWD);
        rd_oor  = acc_ok && i_read  && (32'(i_raddr) >= WORDWD);
        wr_in   = acc_ok && i_write && (32'(i_waddr) <  WORDWD);
        wr_oor  = acc_ok && i_write && (32'(i_waddr) >= WORDWD);
        fill_we = (state_q == ST_INIT) && !i_rst;
    end

    // Expand the per-lane mask into a per-bit mask.
    always_comb begin
        lane_bits = '0;
        for (int j = 0; j < NLANE; j++) begin
            lane_bits[j*LANEWD +: LANEWD] = {LANEWD{i_wmsk[j]}};
        end
    end

    // Read word selection; out-of-range reads load zero.
    always_comb begin
        rd_word_d = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (rd_in) begin
                rd_word_d[k] = mem_q[k][i_raddr];
`ifdef RF_BYPASS_EN
                if (wr_in && (i_waddr == i_raddr) && i_wen[k]) begin
                    rd_word_d[k] = (mem_q[k][i_raddr] & ~lane_bits) | (i_wdata[k] & lane_bits);
                end
`endif
            end
        end
    end

    // Storage: zero-fill during INIT, masked writes in IDLE.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < SIZE; k++) begin
            if (fill_we) begin
                mem_q[k][fill_q] <= '0;
            end else if (wr_in && i_wen[k]) begin
                mem_q[k][i_waddr] <= (mem_q[k][i_waddr] & ~lane_bits) | (i_wdata[k] & lane_bits);
            end
        end
    end

    // Sequencer FSM with registered read/ready/error outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_INIT;
            fill_q   <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    if (32'(fill_q) == WORDWD - 1) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        fill_q  <= '0;
                    end else begin
                        fill_q  <= fill_q + 1'b1;
                    end
                end
                default: begin
                    rvalid_q <= i_read;
                    if (i_read) begin
                        rdata_q <= rd_word_d;
                    end
                    err_q <= rd_oor || wr_oor;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_rf_2p_msk_bank.sv
// Self-checking bench for rf_2p_msk_bank (WORDWD=12, DWD=16, LANEWD=4, SIZE=2).
module tb_rf_2p_msk_bank;

    localparam int W = 12;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              o_ready;
    logic              i_read = 1'b0;
    logic [3:0]        i_raddr = '0;
    logic              o_rvalid;
    logic [1:0][15:0]  o_rdata;
    logic              i_write = 1'b0;
    logic [3:0]        i_waddr = '0;
    logic [1:0]        i_wen = '0;
    logic [3:0]        i_wmsk = '0;
    logic [1:0][15:0]  i_wdata = '0;
    logic              o_err;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0]       mm [2][W];
    logic [1:0][15:0]  exp_rdata;

    always #5 i_clk = ~i_clk;

    rf_2p_msk_bank #(.WORDWD(W), .DWD(16), .LANEWD(4), .SIZE(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready),
        .i_read(i_read), .i_raddr(i_raddr), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .i_write(i_write), .i_waddr(i_waddr), .i_wen(i_wen), .i_wmsk(i_wmsk),
        .i_wdata(i_wdata), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted-state cycle: apply request, predict, clock, compare, update model.
    task automatic cyc(input logic rd, input logic [3:0] ra, input logic wr, input logic [3:0] wa,
                       input logic [1:0] wen, input logic [3:0] msk, input logic [31:0] wd);
        logic [15:0]      bm;
        logic [1:0][15:0] nw;
        logic [1:0][15:0] wdv;
        logic             exp_err;
        wdv = wd;
        i_read = rd; i_raddr = ra; i_write = wr; i_waddr = wa;
        i_wen = wen; i_wmsk = msk; i_wdata = wdv;
        bm = '0;
        for (int j = 0; j < 4; j++) if (msk[j]) bm = bm | (16'hF << (4*j));
        for (int k = 0; k < 2; k++) begin
            nw[k] = '0;
            if (int'(wa) < W) begin
                nw[k] = mm[k][wa];
                if (wr && wen[k]) nw[k] = (mm[k][wa] & ~bm) | (wdv[k] & bm);
            end
        end
        if (rd) begin
            for (int k = 0; k < 2; k++) begin
                if (int'(ra) >= W) exp_rdata[k] = '0;
`ifdef RF_BYPASS_EN
                else if (wr && wa == ra) exp_rdata[k] = nw[k];
`endif
                else exp_rdata[k] = mm[k][ra];
            end
        end
        exp_err = (rd && int'(ra) >= W) || (wr && int'(wa) >= W);
        @(posedge i_clk); #1;
        chk("rvalid", 32'(o_rvalid), 32'(rd));
        chk("rdata0", 32'(o_rdata[0]), 32'(exp_rdata[0]));
        chk("rdata1", 32'(o_rdata[1]), 32'(exp_rdata[1]));
        chk("err", 32'(o_err), 32'(exp_err));
        chk("ready", 32'(o_ready), 32'd1);
        if (wr && int'(wa) < W) for (int k = 0; k < 2; k++) mm[k][wa] = nw[k];
        i_read = 1'b0; i_write = 1'b0;
    endtask

    // Reset pulse with a read pending, then count INIT cycles while hammering accesses.
    task automatic rst_seq();
        int n;
        i_rst = 1'b1; i_read = 1'b1; i_raddr = 4'd2; i_write = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_rvalid", 32'(o_rvalid), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        i_write = 1'b1; i_waddr = 4'd0; i_wen = 2'b11; i_wmsk = 4'hF; i_wdata = '1;
        i_read = 1'b1; i_raddr = 4'd0;
        n = 0;
        while (!o_ready && n < 20) begin
            chk("init_rvalid", 32'(o_rvalid), 32'd0);
            chk("init_err", 32'(o_err), 32'd0);
            @(posedge i_clk); #1;
            n++;
        end
        chk("init_len", 32'(n), 32'd12);
        i_read = 1'b0; i_write = 1'b0;
        for (int k = 0; k < 2; k++) for (int a = 0; a < W; a++) mm[k][a] = '0;
        exp_rdata = '0;
    endtask

    initial begin
        exp_rdata = '0;
        #2;
        rst_seq();

        // Every word reads zero after the fill (addr 0 was written during INIT).
        for (int a = 0; a < W; a++) begin
            cyc(1'b1, 4'(a), 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
            chk("fill_zero", 32'(o_rdata), 32'd0);
        end

        // Lane mask.
        cyc(1'b0, 4'd0, 1'b1, 4'd3, 2'b11, 4'b0101, {16'hABCD, 16'hABCD});
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_mask0", 32'(o_rdata[0]), 32'h0B0D);
        chk("tp_mask1", 32'(o_rdata[1]), 32'h0B0D);

        // Per-array enable.
        cyc(1'b0, 4'd0, 1'b1, 4'd5, 2'b10, 4'hF, {16'h1111, 16'h2222});
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_wen1", 32'(o_rdata[1]), 32'h1111);
        chk("tp_wen0", 32'(o_rdata[0]), 32'h0000);

        // Zero mask / zero enable leave storage untouched.
        cyc(1'b0, 4'd0, 1'b1, 4'd5, 2'b11, 4'h0, 32'hDEADBEEF);
        cyc(1'b0, 4'd0, 1'b1, 4'd5, 2'b00, 4'hF, 32'hDEADBEEF);
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_nomask", 32'(o_rdata), {16'h1111, 16'h0000});

        // Same-address read and write.
        cyc(1'b1, 4'd7, 1'b1, 4'd7, 2'b11, 4'hF, {16'hFFFF, 16'hFFFF});
`ifdef RF_BYPASS_EN
        chk("tp_same", 32'(o_rdata[0]), 32'hFFFF);
`else
        chk("tp_same", 32'(o_rdata[0]), 32'h0000);
`endif
        cyc(1'b1, 4'd7, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_same_after", 32'(o_rdata[0]), 32'hFFFF);

        // Out of range: single error pulse, zero read data, storage unchanged.
        cyc(1'b1, 4'd13, 1'b1, 4'd14, 2'b11, 4'hF, 32'h12345678);
        chk("tp_oor_err", 32'(o_err), 32'd1);
        chk("tp_oor_data", 32'(o_rdata), 32'd0);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_oor_pulse", 32'(o_err), 32'd0);
        for (int a = 0; a < W; a++) cyc(1'b1, 4'(a), 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);

        // Randomised traffic; addresses cover the out-of-range region.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
        end
        // Hot-spot a few addresses so same-address collisions occur often.
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 4'($urandom_range(0, 2)), 1'b1, 4'($urandom_range(0, 2)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
        end

        // Reset in the middle of a read stream.
        cyc(1'b0, 4'd0, 1'b1, 4'd2, 2'b11, 4'hF, {16'h5555, 16'h5555});
        cyc(1'b1, 4'd2, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_pre_rst", 32'(o_rdata[0]), 32'h5555);
        rst_seq();
        cyc(1'b1, 4'd2, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_post_rst", 32'(o_rdata), 32'd0);
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 2'b00, 4'h0, 32'h0);
        chk("tp_init_wr_ignored", 32'(o_rdata), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_2p_msk_bank.md
# rf_2p_msk_bank

Parametrised two-port register-file bank: SIZE independent arrays of WORDWD words × DWD bits, sharing one read and one write address. It is the next-generation behavioural RF for the MEM subsystem, replacing the unmasked per-array 2-port RF in simulation builds. On top of plain read/write it adds:
- per-lane write masking;
- per-array write enables;
- a registered read with a valid flag;
- a post-reset zero-fill sequencer;
- out-of-range address detection.

## Interface
- WORDWD, 12, words per array
- DWD, 16, data bits per word
- LANEWD, 4, bits per write-mask lane; DWD % LANEWD == 0 required; NLANE = DWD/LANEWD
- AWD, $clog2(WORDWD), address width
- SIZE, 1, number of parallel arrays

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- o_ready  out  1  high when the zero-fill is done and accesses are accepted
- i_read  in  1  read request
- i_raddr  in  AWD  read address
- o_rvalid  out  1  o_rdata updated this cycle
- o_rdata  out  DWD×[SIZE]  read data, one word per array
- i_write  in  1  write request
- i_waddr  in  AWD  write address
- i_wen  in  SIZE  per-array write enable
- i_wmsk  in  NLANE  per-lane write mask, shared by all arrays; 1 = lane written
- i_wdata  in  DWD×[SIZE]  write data
- o_err  out  1  one-cycle pulse on an out-of-range access

One clock; reset is synchronous and active-high.

## Operation
- FSM states: INIT, IDLE.
  - i_rst → INIT, fill counter = 0.
  - In INIT, each cycle writes all-zero to address fill in every array, then fill++.
  - When fill == WORDWD-1 has been written → IDLE.
  - INIT lasts exactly WORDWD cycles.
- o_ready = (state == IDLE). In INIT, i_read and i_write are ignored: no storage change, o_rvalid = 0, o_err = 0.
- Write (IDLE, i_write=1, i_waddr < WORDWD):
  - Array k is updated only if i_wen[k].
  - Within an updated word, lane j is replaced by i_wdata[k][j*LANEWD +: LANEWD] only if i_wmsk[j]; other lanes keep their value.
  - i_wmsk == 0 or i_wen == 0 → no change, no error.
- Read (IDLE, i_read=1, i_raddr < WORDWD): o_rdata[k] ← mem[k][i_raddr] and o_rvalid = 1 on the next edge.
- No read → o_rdata holds its last value and o_rvalid = 0.
- Out of range (address ≥ WORDWD, only possible when WORDWD is not a power of two):
  - A write with that address is dropped.
  - A read with that address loads o_rdata = 0 and still asserts o_rvalid.
  - o_err pulses one cycle after the access; if read and write are both out of range, a single pulse.
- Same-address read and write in one cycle: see Configuration.
- Reset mid-operation: a pending read is discarded; the sequencer restarts from 0 and overwrites all contents.

## Timing
- Reset values, registered on the reset edge: o_ready=0, o_rvalid=0, o_rdata=0 for all arrays, o_err=0.
- First cycle with o_ready=1: WORDWD cycles after the last cycle i_rst is high.
- Read latency: 1 cycle, request at edge N → data and o_rvalid after edge N+1. Back-to-back reads are allowed every cycle.
- Write latency: the write commits at the edge. A read of the same address issued in a later cycle returns the new data.
- o_err is registered: it is asserted the cycle after the offending request.

## Configuration
- RF_BYPASS_EN defined: for a same-cycle read and write to the same in-range address, o_rdata returns the merged word, i.e. the old word with the masked lanes of enabled arrays replaced by i_wdata (write-first).
- RF_BYPASS_EN undefined: the same case returns the pre-write word (read-first), matching the synthesised macro RFs.

## Test plan
- Reset, WORDWD=12 → o_ready low exactly 12 cycles, then high; reading addresses 0..11 returns 0 with o_rvalid each cycle after the request.
- Write addr 3, data 16'hABCD, i_wmsk=4'b0101, i_wen=all; then read addr 3 → 16'h0B0D on the next cycle.
- SIZE=2, i_wen=2'b10, write addr 5 with data {16'h1111, 16'h2222}, full mask → array 1 holds 16'h1111 and array 0 stays 0.
- Word 7 = 16'h0000; same cycle write addr 7 = 16'hFFFF (full mask) and read addr 7 → o_rdata 16'hFFFF with RF_BYPASS_EN, 16'h0000 without.
- Read addr 13 and write addr 14 (WORDWD=12) → o_rdata=0, o_rvalid=1, a single o_err pulse, storage unchanged.
- Assert i_rst for 1 cycle mid read stream after writing 16'h5555 to addr 2 → o_rvalid drops, o_ready low 12 cycles, then read addr 2 returns 0.
